// File: rtl/rv_register_file_if.sv
// Register-file access bundle: one write port (rd/result from writeback)
// and two read ports (rs1/rs2 from decode). The master drives addresses
// and write data; the slave is the register file and returns read data.
interface rv_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;

    modport master (
        output we, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2
    );
endinterface

// File: rtl/rv_register_file.sv
// RV32I integer register file: x1..x31 of storage, x0 hardwired to zero,
// two combinational read ports and one synchronous write port.
// Synchronous active-high reset clears x1..x31 and wins over a write.
// Optional feature macro RF_BYPASS_EN: forwards the write data to a read
// port that addresses the register being written in the same cycle
// (never for x0, never while rst is high). Undefined means reads always
// return the stored array contents.
module rv_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic                clk,
    input logic                rst,
    rv_register_file_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // x0 has no storage; index 0 is decoded to a constant zero on read.
    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

    logic write_hit;
    assign write_hit = bus.we && (bus.waddr != '0);

    // Array update: reset clears every register, otherwise one write per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (write_hit) begin
            regs[bus.waddr] <= bus.wdata;
        end
    end

    // Read port 1: zero for x0, stored value otherwise, optionally forwarded.
    always_comb begin
        bus.rdata1 = '0;
        if (bus.raddr1 != '0) begin
            bus.rdata1 = regs[bus.raddr1];
`ifdef RF_BYPASS_EN
            if (!rst && write_hit && (bus.raddr1 == bus.waddr)) begin
                bus.rdata1 = bus.wdata;
            end
`endif
        end
    end

    // Read port 2: same decode as port 1, checked independently.
    always_comb begin
        bus.rdata2 = '0;
        if (bus.raddr2 != '0) begin
            bus.rdata2 = regs[bus.raddr2];
`ifdef RF_BYPASS_EN
            if (!rst && write_hit && (bus.raddr2 == bus.waddr)) begin
                bus.rdata2 = bus.wdata;
            end
`endif
        end
    end
endmodule

// File: tb/tb_rv_register_file.sv
// Directed bench for rv_register_file with a reference array and a
// queue of expected read values checked against both read ports.
module tb_rv_register_file;
    logic clk;
    logic rst;

    rv_register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    rv_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic [31:0] exp1_q [$];
    logic [31:0] exp2_q [$];
    int n_total = 0;
    int n_pass  = 0;

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : model[a];
    endfunction

    task automatic push_exp(input logic [31:0] e1, input logic [31:0] e2);
        exp1_q.push_back(e1);
        exp2_q.push_back(e2);
    endtask

    task automatic check(input string tag);
        logic [31:0] e1;
        logic [31:0] e2;
        e1 = exp1_q.pop_front();
        e2 = exp2_q.pop_front();
        n_total++;
        assert (bus.rdata1 === e1) n_pass++;
        else $error("FAIL %s port1: observed %h expected %h", tag, bus.rdata1, e1);
        n_total++;
        assert (bus.rdata2 === e2) n_pass++;
        else $error("FAIL %s port2: observed %h expected %h", tag, bus.rdata2, e2);
    endtask

    task automatic do_read(input logic [4:0] a1, input logic [4:0] a2, input string tag);
        @(negedge clk);
        bus.raddr1 = a1;
        bus.raddr2 = a2;
        push_exp(model_rd(a1), model_rd(a2));
        #2;
        check(tag);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we    = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        @(posedge clk);
        if (a != 5'd0) model[a] = d;
        #1;
        bus.we = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        bus.we     = 1'b0;
        bus.waddr  = '0;
        bus.wdata  = '0;
        bus.raddr1 = '0;
        bus.raddr2 = '0;

        // x0 reads zero even before any reset
        do_read(5'd0, 5'd0, "x0_pre_reset");

        do_reset();
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'(31 - i), "reset_all");
        end

        write_reg(5'd1, 32'h1234_5678);
        do_read(5'd1, 5'd0, "write_x1");
        write_reg(5'd2, 32'hDEAD_BEEF);
        do_read(5'd1, 5'd2, "read_x1_x2");
        do_read(5'd2, 5'd2, "same_addr_both");

        write_reg(5'd0, 32'hFFFF_FFFF);
        do_read(5'd0, 5'd0, "x0_after_write");
        do_read(5'd1, 5'd2, "x1_x2_unchanged");

        // same-cycle read/write hazard on x3
        write_reg(5'd3, 32'h0F0F_0F0F);
        @(negedge clk);
        bus.we     = 1'b1;
        bus.waddr  = 5'd3;
        bus.wdata  = 32'hA5A5_A5A5;
        bus.raddr1 = 5'd3;
        bus.raddr2 = 5'd1;
`ifdef RF_BYPASS_EN
        push_exp(32'hA5A5_A5A5, model_rd(5'd1));
`else
        push_exp(model_rd(5'd3), model_rd(5'd1));
`endif
        #2;
        check("hazard_pre_edge");
        @(posedge clk);
        model[3] = 32'hA5A5_A5A5;
        #1;
        push_exp(32'hA5A5_A5A5, model_rd(5'd1));
        check("hazard_post_edge");
        bus.we = 1'b0;

        // x0 is never forwarded
        @(negedge clk);
        bus.we     = 1'b1;
        bus.waddr  = 5'd0;
        bus.wdata  = 32'hFFFF_FFFF;
        bus.raddr1 = 5'd0;
        bus.raddr2 = 5'd0;
        push_exp(32'h0, 32'h0);
        #2;
        check("x0_no_forward");
        @(posedge clk);
        #1;
        bus.we = 1'b0;

        // back-to-back writes to x4: each value visible after its edge
        @(negedge clk);
        bus.we     = 1'b1;
        bus.waddr  = 5'd4;
        bus.wdata  = 32'h1111_0004;
        bus.raddr1 = 5'd4;
        bus.raddr2 = 5'd3;
        @(posedge clk);
        model[4] = 32'h1111_0004;
        #1;
        push_exp(model_rd(5'd4), model_rd(5'd3));
        check("consec_first");
        @(negedge clk);
        bus.wdata = 32'h2222_0004;
        @(posedge clk);
        model[4] = 32'h2222_0004;
        #1;
        bus.we = 1'b0;
        push_exp(model_rd(5'd4), model_rd(5'd3));
        check("consec_last_wins");

        // random writes and reads against the reference array
        for (int k = 0; k < 12; k++) begin
            write_reg(5'($urandom_range(0, 31)), $urandom);
            do_read(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), "random");
        end

        // reset colliding with a write to x5
        write_reg(5'd5, 32'h0000_0055);
        @(negedge clk);
        rst        = 1'b1;
        bus.we     = 1'b1;
        bus.waddr  = 5'd5;
        bus.wdata  = 32'h1111_1111;
        bus.raddr1 = 5'd5;
        bus.raddr2 = 5'd4;
        push_exp(model_rd(5'd5), model_rd(5'd4));
        #2;
        check("rst_pre_edge_no_effect");
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        push_exp(32'h0, 32'h0);
        check("rst_wins_over_write");
        rst    = 1'b0;
        bus.we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            do_read(5'(i), 5'((i + 7) % 32), "reset_again_all");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
